// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: opcode and FSM state encodings.
package usr_pkg;

    typedef enum logic [2:0] {
        USR_NOP   = 3'd0,
        USR_LOAD  = 3'd1,
        USR_SHL   = 3'd2,
        USR_SHR   = 3'd3,
        USR_ROL   = 3'd4,
        USR_ROR   = 3'd5,
        USR_ASR   = 3'd6,
        USR_CLEAR = 3'd7
    } usr_op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } usr_state_e;

    // Opcodes that take a count and run through the SHIFT state.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op >= 3'd2) && (op <= 3'd6);
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-bit step of the shift register for one opcode.
// out_bit is the bit that leaves the register on this step.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic             serial_in,
    output logic [WIDTH-1:0] next_data,
    output logic             out_bit
);

    // One-position move; non-shift opcodes pass the data through untouched.
    always_comb begin
        next_data = data;
        out_bit   = 1'b0;
        case (usr_op_e'(op))
            USR_SHL: begin
                next_data = {data[WIDTH-2:0], serial_in};
                out_bit   = data[WIDTH-1];
            end
            USR_SHR: begin
                next_data = {serial_in, data[WIDTH-1:1]};
                out_bit   = data[0];
            end
            USR_ROL: begin
                next_data = {data[WIDTH-2:0], data[WIDTH-1]};
                out_bit   = data[WIDTH-1];
            end
            USR_ROR: begin
                next_data = {data[0], data[WIDTH-1:1]};
                out_bit   = data[0];
            end
            USR_ASR: begin
                next_data = {data[WIDTH-1], data[WIDTH-1:1]};
                out_bit   = data[0];
            end
            default: begin
                next_data = data;
                out_bit   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// Parametrised multi-mode shift register with a valid/ready command port.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | cmd_ready high; single-cycle ops complete on the accept edge
//  SHIFT | one single-bit step per edge until the remaining count hits 0
//
// Counts above WIDTH are clamped, so a WIDTH-step ASR of a negative value
// saturates to all-ones. Commands offered while in SHIFT are dropped.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] ONE_AMT   = AMT_W'(1);

    usr_state_e       state_q, state_next;
    usr_op_e          op_q, op_next;
    logic [AMT_W-1:0] rem_q, rem_next;
    logic [WIDTH-1:0] data_q, data_next;
    logic             sout_q, sout_next;
    logic             done_q, done_next;

    logic [AMT_W-1:0] amt_clamped;
    logic [WIDTH-1:0] step_data;
    logic             step_bit;

    assign amt_clamped = (cmd_amt > WIDTH_AMT) ? WIDTH_AMT : cmd_amt;

    usr_shift_step #(.WIDTH(WIDTH)) u_step (
        .op        (op_q),
        .data      (data_q),
        .serial_in (serial_in),
        .next_data (step_data),
        .out_bit   (step_bit)
    );

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= USR_NOP;
            rem_q   <= '0;
            data_q  <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            op_q    <= op_next;
            rem_q   <= rem_next;
            data_q  <= data_next;
            sout_q  <= sout_next;
            done_q  <= done_next;
        end
    end

    // Next-state and datapath decode: accept in IDLE, step in SHIFT.
    always_comb begin
        state_next = state_q;
        op_next    = op_q;
        rem_next   = rem_q;
        data_next  = data_q;
        sout_next  = sout_q;
        done_next  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (usr_op_e'(cmd_op))
                        USR_NOP: begin
                            done_next = 1'b1;
                        end
                        USR_LOAD: begin
                            data_next = load_data;
                            done_next = 1'b1;
                        end
                        USR_CLEAR: begin
                            data_next = '0;
                            sout_next = 1'b0;
                            done_next = 1'b1;
                        end
                        default: begin
                            if (amt_clamped == '0) begin
                                done_next = 1'b1;
                            end else begin
                                op_next    = usr_op_e'(cmd_op);
                                rem_next   = amt_clamped;
                                state_next = SHIFT;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                data_next = step_data;
                sout_next = step_bit;
                rem_next  = rem_q - ONE_AMT;
                if (rem_q == ONE_AMT) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q == SHIFT);
    assign data_out   = data_q;
    assign serial_out = sout_q;
    assign done       = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register at WIDTH=8, plus seeded random
// command streams at WIDTH=2 and WIDTH=64 against a behavioural model.
`timescale 1ns/1ps
module tb_universal_shift_register;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        v8 = 1'b0, v2 = 1'b0, v64 = 1'b0;
    logic [2:0]  c_op = 3'd0;
    logic [6:0]  c_amt = 7'd0;
    logic [63:0] c_load = 64'd0;
    logic        c_sin = 1'b0;

    logic        ready8, sout8, busy8, done8;
    logic [7:0]  data8;
    logic        ready2, sout2, busy2, done2;
    logic [1:0]  data2;
    logic        ready64, sout64, busy64, done64;
    logic [63:0] data64;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    universal_shift_register #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(v8), .cmd_ready(ready8),
        .cmd_op(c_op), .cmd_amt(c_amt[3:0]), .load_data(c_load[7:0]),
        .serial_in(c_sin), .data_out(data8), .serial_out(sout8),
        .busy(busy8), .done(done8)
    );

    universal_shift_register #(.WIDTH(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(v2), .cmd_ready(ready2),
        .cmd_op(c_op), .cmd_amt(c_amt[1:0]), .load_data(c_load[1:0]),
        .serial_in(c_sin), .data_out(data2), .serial_out(sout2),
        .busy(busy2), .done(done2)
    );

    universal_shift_register #(.WIDTH(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(v64), .cmd_ready(ready64),
        .cmd_op(c_op), .cmd_amt(c_amt), .load_data(c_load),
        .serial_in(c_sin), .data_out(data64), .serial_out(sout64),
        .busy(busy64), .done(done64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command to the WIDTH=8 instance for one accept edge.
    task automatic issue8(input logic [2:0] op, input logic [6:0] amt, input logic [7:0] ld);
        c_op = op; c_amt = amt; c_load = {56'd0, ld}; v8 = 1'b1;
        tick();
        v8 = 1'b0;
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        while (!done8 && n < 100) begin
            tick();
            n++;
        end
        chk("done8_seen", {63'd0, done8}, 64'd1);
    endtask

    // Behavioural single step at an arbitrary width (bits above w stay zero).
    function automatic void mstep(input logic [2:0] op, input int w, input logic sin,
                                  inout logic [63:0] d, inout logic so);
        logic [63:0] mask;
        logic msb, lsb;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        msb = d[w-1];
        lsb = d[0];
        case (op)
            3'd2: begin d = ((d << 1) | 64'(sin)) & mask;        so = msb; end
            3'd3: begin d = (d >> 1) | (64'(sin) << (w - 1));    so = lsb; end
            3'd4: begin d = ((d << 1) | 64'(msb)) & mask;        so = msb; end
            3'd5: begin d = (d >> 1) | (64'(lsb) << (w - 1));    so = lsb; end
            3'd6: begin d = (d >> 1) | (64'(msb) << (w - 1));    so = lsb; end
            default: ;
        endcase
    endfunction

    function automatic logic [63:0] out_data(input int w);
        return (w == 2) ? {62'd0, data2} : data64;
    endfunction
    function automatic logic out_sout(input int w);
        return (w == 2) ? sout2 : sout64;
    endfunction
    function automatic logic out_done(input int w);
        return (w == 2) ? done2 : done64;
    endfunction
    function automatic logic out_busy(input int w);
        return (w == 2) ? busy2 : busy64;
    endfunction
    function automatic logic out_ready(input int w);
        return (w == 2) ? ready2 : ready64;
    endfunction

    task automatic run_rand(input int w, input int ncmd);
        logic [63:0] ed, mask;
        logic        es;
        logic [2:0]  op;
        int          amt, amtc, n, exp_n;
        ed = 64'd0;
        es = 1'b0;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        for (int i = 0; i < ncmd; i++) begin
            op   = 3'($urandom_range(0, 7));
            amt  = (w == 2) ? $urandom_range(0, 3) : $urandom_range(0, 127);
            c_op = op; c_amt = 7'(amt); c_load = {$urandom, $urandom};
            c_sin = 1'($urandom_range(0, 1));
            chk("rnd_ready", {63'd0, out_ready(w)}, 64'd1);
            if (w == 2) v2 = 1'b1; else v64 = 1'b1;
            tick();
            v2 = 1'b0; v64 = 1'b0;
            n = 0;
            while (!out_done(w) && n < 200) begin
                tick();
                n++;
            end
            amtc  = (amt > w) ? w : amt;
            exp_n = 0;
            case (op)
                3'd1: ed = c_load & mask;
                3'd7: begin ed = 64'd0; es = 1'b0; end
                3'd2, 3'd3, 3'd4, 3'd5, 3'd6: begin
                    exp_n = amtc;
                    for (int k = 0; k < amtc; k++) mstep(op, w, c_sin, ed, es);
                end
                default: ;
            endcase
            chk("rnd_cycles", 64'(n), 64'(exp_n));
            chk("rnd_data", out_data(w), ed);
            chk("rnd_sout", {63'd0, out_sout(w)}, {63'd0, es});
            chk("rnd_busy", {63'd0, out_busy(w)}, 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] bits;

        // Reset values while reset is held.
        #12;
        chk("rst_data", {56'd0, data8}, 64'd0);
        chk("rst_sout", {63'd0, sout8}, 64'd0);
        chk("rst_busy", {63'd0, busy8}, 64'd0);
        chk("rst_done", {63'd0, done8}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("rst_ready", {63'd0, ready8}, 64'd1);

        // LOAD 0xA5, then ROL by 3.
        issue8(3'd1, 7'd0, 8'hA5);
        chk("load_data", {56'd0, data8}, 64'hA5);
        chk("load_done", {63'd0, done8}, 64'd1);
        tick();
        chk("load_done_pulse", {63'd0, done8}, 64'd0);
        issue8(3'd4, 7'd3, 8'h00);
        chk("rol_busy", {63'd0, busy8}, 64'd1);
        chk("rol_ready_low", {63'd0, ready8}, 64'd0);
        wait_done8(n);
        chk("rol_cycles", 64'(n), 64'd3);
        chk("rol_data", {56'd0, data8}, 64'h2D);
        chk("rol_sout", {63'd0, sout8}, 64'd1);
        chk("rol_ready", {63'd0, ready8}, 64'd1);

        // LOAD 0x80, ASR by 12 (clamped to 8); a LOAD offered mid-shift is dropped.
        issue8(3'd1, 7'd0, 8'h80);
        issue8(3'd6, 7'd12, 8'h00);
        n = 0;
        while (!done8 && n < 100) begin
            if (n == 2) begin
                c_op = 3'd1; c_load = 64'd0; v8 = 1'b1;
            end else begin
                v8 = 1'b0;
            end
            tick();
            n++;
        end
        v8 = 1'b0;
        chk("asr_cycles", 64'(n), 64'd8);
        chk("asr_data", {56'd0, data8}, 64'hFF);
        chk("asr_sout", {63'd0, sout8}, 64'd1);

        // LOAD 0, SHL by 8 streaming 1,0,1,1,0,0,1,0.
        issue8(3'd1, 7'd0, 8'h00);
        issue8(3'd2, 7'd8, 8'h00);
        bits = 8'b1011_0010;
        for (int k = 7; k >= 0; k--) begin
            c_sin = bits[k];
            tick();
        end
        c_sin = 1'b0;
        chk("shl_done", {63'd0, done8}, 64'd1);
        chk("shl_data", {56'd0, data8}, 64'hB2);
        chk("shl_sout", {63'd0, sout8}, 64'd0);

        // SHR with zero count leaves data alone and completes next cycle.
        issue8(3'd3, 7'd0, 8'h00);
        chk("shr0_done", {63'd0, done8}, 64'd1);
        chk("shr0_data", {56'd0, data8}, 64'hB2);
        chk("shr0_ready", {63'd0, ready8}, 64'd1);

        // ROR by 2, then LOAD accepted on the done cycle with no bubble.
        tick();
        issue8(3'd5, 7'd2, 8'h00);
        wait_done8(n);
        chk("ror_cycles", 64'(n), 64'd2);
        chk("ror_data", {56'd0, data8}, 64'hAC);
        chk("ror_sout", {63'd0, sout8}, 64'd1);
        chk("b2b_ready", {63'd0, ready8}, 64'd1);
        issue8(3'd1, 7'd0, 8'h5A);
        chk("b2b_data", {56'd0, data8}, 64'h5A);
        chk("b2b_done", {63'd0, done8}, 64'd1);

        // LOAD 0x3C then CLEAR zeroes data and serial_out.
        issue8(3'd1, 7'd0, 8'h3C);
        chk("pre_clr_sout", {63'd0, sout8}, 64'd1);
        issue8(3'd7, 7'd0, 8'h00);
        chk("clr_data", {56'd0, data8}, 64'd0);
        chk("clr_sout", {63'd0, sout8}, 64'd0);
        chk("clr_done", {63'd0, done8}, 64'd1);

        // Reset in the middle of an SHL by 5 with three steps remaining.
        issue8(3'd1, 7'd0, 8'hF0);
        issue8(3'd2, 7'd5, 8'h00);
        tick();
        tick();
        chk("mid_busy", {63'd0, busy8}, 64'd1);
        chk("mid_sout", {63'd0, sout8}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_data", {56'd0, data8}, 64'd0);
        chk("mrst_sout", {63'd0, sout8}, 64'd0);
        chk("mrst_busy", {63'd0, busy8}, 64'd0);
        chk("mrst_done", {63'd0, done8}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("mrst_ready", {63'd0, ready8}, 64'd1);
        chk("mrst_nodone1", {63'd0, done8}, 64'd0);
        tick();
        chk("mrst_nodone2", {63'd0, done8}, 64'd0);

        // Random command streams at the width extremes.
        run_rand(2, 60);
        run_rand(64, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised, multi-mode shift register; successor to the team's fixed 4-bit left/right shifter.
- Adds configurable width, parallel load, rotate, arithmetic shift and multi-position shift commands.
- A valid/ready command interface and a done pulse let a controller FSM sequence it without cycle counting.
- Sits between serial-link logic and parallel datapath registers.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- AMT_W, $clog2(WIDTH+1), derived localparam; width of the shift-amount field.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command (IDLE).
- cmd_op  input  3  operation code, see Behaviour.
- cmd_amt  input  AMT_W  shift/rotate count.
- load_data  input  WIDTH  parallel load value.
- serial_in  input  1  fill bit for logical shifts.
- data_out  output  WIDTH  register contents.
- serial_out  output  1  last bit shifted or rotated out.
- busy  output  1  multi-cycle shift in progress.
- done  output  1  one-cycle pulse on command completion.

Behaviour:
- Reset (reset_n low, async): data_out=0, serial_out=0, busy=0, done=0, state=IDLE, cmd_ready=1 after release. Reset mid-shift aborts the command with no done pulse.
- cmd_op codes:
  - 0 NOP.
  - 1 LOAD: data_out<=load_data.
  - 2 SHL: data_out<={data_out[WIDTH-2:0],serial_in}.
  - 3 SHR: data_out<={serial_in,data_out[WIDTH-1:1]}.
  - 4 ROL.
  - 5 ROR.
  - 6 ASR: msb replicated.
  - 7 CLEAR: data_out<=0, serial_out<=0.
- States: IDLE, SHIFT. cmd_ready = (state==IDLE); busy = (state==SHIFT).
- Accept on the edge where cmd_valid && cmd_ready; while busy, cmd_valid is ignored and not queued.
- NOP/LOAD/CLEAR: register updates on the accept edge; stays IDLE; done=1 for the following cycle.
- Ops 2..6 with cmd_amt=0: no change; done next cycle; stays IDLE.
- Ops 2..6 with cmd_amt=N>0:
  - Accept edge latches op and rem=N; state goes to SHIFT.
  - Each SHIFT edge performs one single-bit step and decrements rem.
  - The edge where rem==1 performs the final step and returns to IDLE.
  - done=1 and cmd_ready=1 in the cycle after the Nth step; total N+1 cycles from accept to done.
- cmd_amt > WIDTH is clamped to WIDTH.
- serial_in is sampled live at every SHL/SHR step, so bits can be streamed one per cycle.
- serial_out updates on every shift/rotate step:
  - left ops: old data_out[WIDTH-1];
  - right ops: old data_out[0].
  - Held otherwise; CLEAR and reset zero it.
- ASR fill = current msb at each step, so a negative value saturates to all-ones after WIDTH steps.
- A new command may be accepted in the same cycle done is high (back-to-back commands, no bubble).
- All outputs registered except cmd_ready and busy, which decode the state register directly.

Decomposition:
- Package usr_pkg:
  - op enum (USR_NOP, USR_LOAD, USR_SHL, USR_SHR, USR_ROL, USR_ROR, USR_ASR, USR_CLEAR);
  - state enum (IDLE, SHIFT).
- Sub-module usr_shift_step: combinational single-bit step (op, data, serial_in) -> (next_data, out_bit). Used by the top-level FSM.

Test Plan:
- Reset: reset_n low mid-SHIFT with rem=3 -> data_out=0, serial_out=0, busy=0, no done; cmd_ready=1 after release.
- WIDTH=8, LOAD 0xA5 -> data_out=0xA5 one edge after accept; done pulses 1 cycle; then ROL amt=3 -> busy for 3 cycles, data_out=0x2D, serial_out=1, done 4 cycles after accept.
- LOAD 0x80, ASR amt=12 (clamped to 8) -> data_out=0xFF after 8 steps; cmd_valid pulsed during busy is ignored.
- LOAD 0x00, SHL amt=8 with serial_in streaming 1,0,1,1,0,0,1,0 -> data_out=0xB2.
- SHR amt=0 -> data_out unchanged; done next cycle. LOAD held valid on the done cycle of a prior ROR -> accepted with no bubble.
- LOAD 0x3C, then CLEAR -> data_out=0x00, serial_out=0; all 8 opcodes exercised at WIDTH=2 and WIDTH=64 with randomized comparison against a reference model.
